// File: rtl/cla_sub32_seq.sv
// Multi-cycle subtractor D = A - B - BIN (mod 2^WIDTH), SLICE bits per cycle
// through chained 4-bit carry-lookahead slices with a registered carry between cycles.
module cla_sub32_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             BOUT,
  output logic             OVF,
  output logic             Z
);

  localparam int unsigned N      = WIDTH / SLICE;
  localparam int unsigned NG     = SLICE / 4;
  localparam int unsigned STEP_W = $clog2(N);

  typedef logic [N-1:0][SLICE-1:0] word_t;
  typedef logic [NG-1:0][3:0]      slice_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  word_t             a_q, a_d;
  word_t             nb_q, nb_d;
  word_t             d_q, d_d;
  logic              carry_q, carry_d;
  logic              bout_q, bout_d;
  logic              ovf_q, ovf_d;
  logic              z_q, z_d;

  slice_t a_sl, nb_sl, s_sl;
  logic   c;

  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                      input logic cin);
    logic [3:0] g, p, cv;
    logic       c4;
    g     = a & b;
    p     = a ^ b;
    cv[0] = cin;
    cv[1] = g[0] | (p[0] & cin);
    cv[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    cv[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c4    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & cin);
    return {c4, p ^ cv};
  endfunction

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign D         = d_q;
  assign BOUT      = bout_q;
  assign OVF       = ovf_q;
  assign Z         = z_q;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    nb_d    = nb_q;
    d_d     = d_q;
    carry_d = carry_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    z_d     = z_q;

    // A + ~B + carry for the current slice, rippled across the 4-bit CLA groups.
    a_sl  = a_q[step_q];
    nb_sl = nb_q[step_q];
    s_sl  = '0;
    c     = carry_q;
    for (int unsigned k = 0; k < NG; k++) begin
      {c, s_sl[k]} = cla4(a_sl[k], nb_sl[k], c);
    end

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          nb_d    = ~B;
          carry_d = ~BIN;
          step_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        d_d[step_q] = s_sl;
        carry_d     = c;
        step_d      = step_q + 1'b1;
        if (step_q == STEP_W'(N - 1)) begin
          // B's sign bit is recovered from the stored complement.
          bout_d  = ~c;
          ovf_d   = (a_q[N-1][SLICE-1] == nb_q[N-1][SLICE-1]) &&
                    (d_d[N-1][SLICE-1] != a_q[N-1][SLICE-1]);
          z_d     = (d_d == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      a_q     <= '0;
      nb_q    <= '0;
      d_q     <= '0;
      carry_q <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      nb_q    <= nb_d;
      d_q     <= d_d;
      carry_q <= carry_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      z_q     <= z_d;
    end
  end

endmodule

// File: tb/tb_cla_sub32_seq.sv
// Directed and randomized checks of cla_sub32_seq: results, flags, latency,
// output stall behaviour and abort on reset.
module tb_cla_sub32_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A, B;
  logic        BIN;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] D;
  logic        BOUT, OVF, Z;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cla_sub32_seq #(.WIDTH(32), .SLICE(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .BIN       (BIN),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .BOUT      (BOUT),
    .OVF       (OVF),
    .Z         (Z)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns #1 after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic bin);
    int w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_before_issue", {31'b0, in_ready}, 32'd1);
    A = a; B = b; BIN = bin; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = $urandom; B = $urandom; BIN = 1'b0;
  endtask

  // Counts edges after acceptance until out_valid is seen at a negedge.
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 20);
    check("done_timeout", {31'b0, out_valid}, 32'd1);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("release_out_valid", {31'b0, out_valid}, 32'd0);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bin,
                        output logic [31:0] d, output logic bout, output logic ovf,
                        output logic z, output int lat);
    issue(a, b, bin);
    wait_done(lat);
    d = D; bout = BOUT; ovf = OVF; z = Z;
    release_out();
  endtask

  logic [31:0] d;
  logic        bout, ovf, z;
  int          lat;

  initial begin
    logic [32:0] full;
    logic [31:0] ra, rb, ed;
    logic        rbin, eovf;
    logic        seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; BIN = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready",  {31'b0, in_ready},  32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_D",         D,                  32'd0);
    check("rst_flags",     {29'b0, BOUT, OVF, Z}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);

    run_op(32'd5, 32'd3, 1'b0, d, bout, ovf, z, lat);
    check("t1_D", d, 32'd2);
    check("t1_flags", {29'b0, bout, ovf, z}, 32'd0);
    check("t1_latency", lat, 32'd4);

    run_op(32'd0, 32'd1, 1'b0, d, bout, ovf, z, lat);
    check("t2a_D", d, 32'hFFFF_FFFF);
    check("t2a_flags", {29'b0, bout, ovf, z}, 32'b100);

    run_op(32'h100, 32'd1, 1'b0, d, bout, ovf, z, lat);
    check("t2b_D", d, 32'h0000_00FF);
    check("t2b_flags", {29'b0, bout, ovf, z}, 32'b000);

    run_op(32'h8000_0000, 32'd1, 1'b0, d, bout, ovf, z, lat);
    check("t3a_D", d, 32'h7FFF_FFFF);
    check("t3a_flags", {29'b0, bout, ovf, z}, 32'b010);

    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, d, bout, ovf, z, lat);
    check("t3b_D", d, 32'h8000_0000);
    check("t3b_flags", {29'b0, bout, ovf, z}, 32'b110);

    run_op(32'h1234_5678, 32'h1234_5677, 1'b1, d, bout, ovf, z, lat);
    check("t4_D", d, 32'd0);
    check("t4_flags", {29'b0, bout, ovf, z}, 32'b001);

    // Output stall: result held, input side ignored.
    issue(32'd100, 32'd58, 1'b0);
    wait_done(lat);
    for (int i = 0; i < 3; i++) begin
      in_valid = ~in_valid;
      A = 32'hDEAD_BEEF;
      B = 32'h1;
      @(posedge clk);
      @(negedge clk);
      check("t5_hold_D", D, 32'd42);
      check("t5_hold_flags", {28'b0, out_valid, BOUT, OVF, Z}, 32'b1000);
      check("t5_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    release_out();
    check("t5_idle_in_ready", {31'b0, in_ready}, 32'd1);
    issue(32'd7, 32'd10, 1'b0);
    @(negedge clk);
    check("t5_accepted", {31'b0, in_ready}, 32'd0);
    wait_done(lat);
    check("t5_next_D", D, 32'hFFFF_FFFD);
    check("t5_next_bout", {31'b0, BOUT}, 32'd1);
    check("t5_next_latency", lat, 32'd4);
    release_out();

    // Reset during the second RUN cycle aborts the operation.
    issue(32'd1000, 32'd1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_rst_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_out_valid", {31'b0, out_valid}, 32'd0);
    check("t6_in_ready", {31'b0, in_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("t6_no_stale_valid", {31'b0, seen}, 32'd0);
    run_op(32'd9, 32'd4, 1'b0, d, bout, ovf, z, lat);
    check("t6_next_D", d, 32'd5);

    // Randomized scoreboard against a 33-bit reference subtraction.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = (i % 4 == 0) ? ra : $urandom;
      rbin = 1'($urandom_range(0, 1));
      full = {1'b0, ra} - {1'b0, rb} - {32'b0, rbin};
      ed   = full[31:0];
      eovf = (ra[31] != rb[31]) && (ed[31] != ra[31]);
      run_op(ra, rb, rbin, d, bout, ovf, z, lat);
      check("rand_D", d, ed);
      check("rand_flags", {29'b0, bout, ovf, z}, {29'b0, full[32], eovf, (ed == 32'd0)});
      check("rand_latency", lat, 32'd4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
